apb_master: RTL and testbench

Requester side of the team's APB link: it accepts single read/write commands on a simple valid/ready command port and drives the APB `psel`/`penable`/`pwrite`/`paddr`/`pwdata` signals. It samples `prdata`/`pready` from the peripheral and returns one response pulse per command. Wait states are honoured, and a transfer with no `pready` is aborted after a bounded number of ACCESS cycles. It sits between a local controller or bus bridge and the existing APB peripherals on `pclk`.

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_wait_timer.sv | 39 +++
 rtl/apb_master.sv | 122 ++++++++++++
 tb/tb_apb_master.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and default bus geometry.
package apb_pkg;

    localparam int APB_ADDR_W  = 5;
    localparam int APB_DATA_W  = 32;
    localparam int APB_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

endpackage : apb_pkg

// File: rtl/apb_wait_timer.sv
// Wait-state counter for the ACCESS phase. Cleared when a transfer starts,
// advanced on each ACCESS cycle without pready, and saturating at the limit
// so it never wraps even if the caller keeps it enabled.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic pclk,
    input  logic prst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Limit is reached once TIMEOUT-1 stalled ACCESS cycles have been counted;
    // the next stalled sample is then the TIMEOUT-th and aborts the transfer.
    assign expired_o = (cnt_q == CW'(TIMEOUT - 1));

    // Next count: clear wins, otherwise count up until the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && !expired_o)
            cnt_d = cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge pclk or negedge prst) begin
        if (!prst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule : apb_wait_timer

// File: rtl/apb_master.sv
// APB requester: takes one command at a time from a valid/ready port, runs
// SETUP/ACCESS on the APB bus with wait-state support and a bounded abort,
// and returns a single-cycle response pulse per command.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR    = APB_ADDR_W,
    parameter int DATA    = APB_DATA_W,
    parameter int TIMEOUT = APB_TIMEOUT
) (
    input  logic            pclk,
    input  logic            prst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [ADDR-1:0] cmd_addr,
    input  logic [DATA-1:0] cmd_wdata,
    output logic            rsp_valid,
    output logic [DATA-1:0] rsp_rdata,
    output logic            rsp_timeout,
    output logic            psel,
    output logic            penable,
    output logic            pwrite,
    output logic [ADDR-1:0] paddr,
    output logic [DATA-1:0] pwdata,
    input  logic [DATA-1:0] prdata,
    input  logic            pready
);

    apb_state_e      state_q;
    logic            psel_q, penable_q, pwrite_q;
    logic [ADDR-1:0] paddr_q;
    logic [DATA-1:0] pwdata_q, rsp_rdata_q;
    logic            rsp_valid_q, rsp_timeout_q;

    logic            tmr_clr, tmr_en, tmr_expired;

    // Counter restarts on every accepted command and only runs while the
    // peripheral is stalling an ACCESS cycle.
    assign tmr_clr = (state_q == ST_IDLE) && cmd_valid;
    assign tmr_en  = (state_q == ST_ACCESS) && !pready;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .pclk      (pclk),
        .prst      (prst),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );

    // Transfer FSM with registered bus and response outputs. Address, data and
    // direction are loaded only on acceptance, so they stay put for the whole
    // transfer and keep their last values while idle.
    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            state_q       <= ST_IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
        end else begin
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        state_q   <= ST_SETUP;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        pwrite_q  <= cmd_write;
                        paddr_q   <= cmd_addr;
                        pwdata_q  <= cmd_wdata;
                    end
                end
                ST_SETUP: begin
                    state_q   <= ST_ACCESS;
                    penable_q <= 1'b1;
                end
                ST_ACCESS: begin
                    // pready is checked first so a completion on the limit
                    // cycle is reported as a normal transfer.
                    if (pready) begin
                        state_q     <= ST_IDLE;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= pwrite_q ? '0 : prdata;
                    end else if (tmr_expired) begin
                        state_q       <= ST_IDLE;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_rdata_q   <= '0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_timeout = rsp_timeout_q;
    assign rsp_rdata   = rsp_rdata_q;

endmodule : apb_master

// File: tb/tb_apb_master.sv
// Directed bench for apb_master (TIMEOUT=4): a table of single transfers with
// hand-computed latency/response, plus back-to-back and mid-transfer reset.
module tb_apb_master;

    localparam int ADDR = 5;
    localparam int DATA = 32;
    localparam int TOUT = 4;
    localparam int NV   = 7;

    logic            pclk = 1'b0;
    logic            prst = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic            cmd_write = 1'b0;
    logic [ADDR-1:0] cmd_addr = '0;
    logic [DATA-1:0] cmd_wdata = '0;
    logic            rsp_valid;
    logic [DATA-1:0] rsp_rdata;
    logic            rsp_timeout;
    logic            psel, penable, pwrite;
    logic [ADDR-1:0] paddr;
    logic [DATA-1:0] pwdata;
    logic [DATA-1:0] prdata = '0;
    logic            pready = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    apb_master #(.ADDR(ADDR), .DATA(DATA), .TIMEOUT(TOUT)) dut (
        .pclk(pclk), .prst(prst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic            write;
        logic [ADDR-1:0] addr;
        logic [DATA-1:0] wdata;
        int              waits;     // ACCESS samples with pready low (99 = never ready)
        logic [DATA-1:0] prdata;
        logic [DATA-1:0] exp_rdata;
        logic            exp_to;
        int              exp_lat;   // handshake edge to rsp_valid, in cycles
    } vec_t;

    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One table transfer. Inputs change and outputs are sampled on negedges.
    task automatic run_vec(input int idx, input vec_t v);
        int lat, psel_cyc, bad;
        bit got;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata;
        pready = 1'b0; prdata = 32'h0BAD_0BAD;
        chk({tag, ".ready_idle"}, {31'd0, cmd_ready}, 32'd1);
        @(posedge pclk);           // E0 handshake
        lat = 0; psel_cyc = 0; bad = 0; got = 0;
        @(negedge pclk);
        cmd_valid = 1'b0; cmd_addr = ~v.addr; cmd_wdata = ~v.wdata; cmd_write = ~v.write;
        while (!got && lat < 20) begin
            if (rsp_valid) begin
                got = 1'b1;
            end else begin
                if (psel) psel_cyc++;
                if (paddr !== v.addr || pwdata !== v.wdata || pwrite !== v.write) bad++;
                if (cmd_ready !== 1'b0 || penable !== (lat >= 1)) bad++;
                // pready during SETUP must be ignored; in ACCESS, low for v.waits samples
                pready = (lat == 0) ? 1'b1 : (lat > v.waits);
                prdata = pready ? v.prdata : 32'h0BAD_0BAD;
                @(posedge pclk);
                lat++;
                @(negedge pclk);
            end
        end
        chk({tag, ".got_rsp"}, {31'd0, got}, 32'd1);
        chk({tag, ".latency"}, lat, v.exp_lat);
        chk({tag, ".psel_cycles"}, psel_cyc, v.exp_lat);
        chk({tag, ".rdata"}, rsp_rdata, v.exp_rdata);
        chk({tag, ".timeout"}, {31'd0, rsp_timeout}, {31'd0, v.exp_to});
        chk({tag, ".stable"}, bad, 0);
        chk({tag, ".end_bus"}, {30'd0, psel, penable}, 32'd0);
        chk({tag, ".ready_rsp"}, {31'd0, cmd_ready}, 32'd1);
        pready = 1'b0;
        @(negedge pclk);
        chk({tag, ".rsp_pulse"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'h03, 32'hDEAD_BEEF, 0,  32'h1111_1111, 32'h0,          1'b0, 2};
        vecs[1] = '{1'b0, 5'h03, 32'h0,         3,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 5};
        vecs[2] = '{1'b0, 5'h1F, 32'h0,         99, 32'h2222_2222, 32'h0,          1'b1, 5};
        vecs[3] = '{1'b1, 5'h1F, 32'h0000_0001, 1,  32'h3333_3333, 32'h0,          1'b0, 3};
        vecs[4] = '{1'b0, 5'h00, 32'h0,         0,  32'h1234_5678, 32'h1234_5678, 1'b0, 2};
        vecs[5] = '{1'b1, 5'h0A, 32'hCAFE_F00D, 99, 32'h4444_4444, 32'h0,          1'b1, 5};
        vecs[6] = '{1'b0, 5'h15, 32'h0,         2,  32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b0, 4};

        // Reset values
        #12;
        chk("rst.bus", {29'd0, psel, penable, pwrite}, 32'd0);
        chk("rst.paddr", {27'd0, paddr}, 32'd0);
        chk("rst.pwdata", pwdata, 32'd0);
        chk("rst.rsp", {30'd0, rsp_valid, rsp_timeout}, 32'd0);
        chk("rst.rdata", rsp_rdata, 32'd0);
        chk("rst.ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge pclk);
        prst = 1'b1;
        @(negedge pclk);

        for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

        // Back-to-back with cmd_valid held: A (write 0x04) then B (read 0x09)
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'h04; cmd_wdata = 32'h0000_AAAA;
        pready = 1'b1; prdata = 32'h7777_0000;
        @(posedge pclk);                              // A accepted
        @(negedge pclk);
        cmd_write = 1'b0; cmd_addr = 5'h09; cmd_wdata = 32'h0;
        chk("b2b.busy_setup", {30'd0, cmd_ready, penable}, 32'd0);
        @(negedge pclk);
        chk("b2b.busy_access", {30'd0, cmd_ready, penable}, 32'd1);
        @(negedge pclk);
        chk("b2b.rspA", {30'd0, rsp_valid, cmd_ready}, 32'd3);
        chk("b2b.paddrA_held", {27'd0, paddr}, 32'h04);
        chk("b2b.idle_gap", {31'd0, psel}, 32'd0);
        @(negedge pclk);
        chk("b2b.setupB", {27'd0, psel, penable, paddr}, {27'd0, 1'b1, 1'b0, 5'h09} >> 0);
        cmd_valid = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        chk("b2b.rspB", {31'd0, rsp_valid}, 32'd1);
        chk("b2b.rdataB", rsp_rdata, 32'h7777_0000);
        pready = 1'b0;

        // Reset in the middle of ACCESS
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'h11;
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(negedge pclk);
        chk("rmid.in_access", {30'd0, psel, penable}, 32'd3);
        #2 prst = 1'b0;
        #1;
        chk("rmid.async_drop", {30'd0, psel, penable}, 32'd0);
        @(negedge pclk);
        pready = 1'b1;
        prst = 1'b1;
        chk("rmid.ready", {31'd0, cmd_ready}, 32'd1);
        chk("rmid.paddr", {27'd0, paddr}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge pclk);
            chk($sformatf("rmid.no_rsp%0d", k), {29'd0, rsp_valid, psel, penable}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule : tb_apb_master
